// File: rtl/rst_sequencer.sv
// Releases NUM_OUT active-low reset domains in order, waiting for each domain's ACK.
// Optional build macro RST_SEQ_REVERSE_ASSERT_EN: software re-reset from DONE re-asserts domains high index first.
`default_nettype none

module rst_sequencer #(
    parameter int NUM_OUT     = 4,
    parameter int HOLD_CYC    = 16,
    parameter int GAP_CYC     = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sw_rst,
    input  logic [NUM_OUT-1:0] ack,
    output logic [NUM_OUT-1:0] seq_rst_n,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int MAX_HG  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int MAX_CYC = (MAX_HG > TIMEOUT_CYC) ? MAX_HG : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUT - 1);

    typedef enum logic [2:0] {
        S_HOLD     = 3'd0,
        S_WAIT_ACK = 3'd1,
        S_GAP      = 3'd2,
        S_DONE     = 3'd3,
        S_FAULT    = 3'd4,
        S_ASSERT   = 3'd5
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [NUM_OUT-1:0] rst_out_nxt;
    logic               busy_nxt, done_nxt, err_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_HOLD;
            idx       <= '0;
            cnt       <= '0;
            seq_rst_n <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            seq_rst_n <= rst_out_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

    // Released bits are always a contiguous run from bit 0, so shifts replace indexed updates.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        cnt_nxt     = cnt;
        rst_out_nxt = seq_rst_n;
        busy_nxt    = busy;
        done_nxt    = done;
        err_nxt     = err;

        case (state)
            S_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    rst_out_nxt = NUM_OUT'(1);
                    cnt_nxt     = '0;
                    state_nxt   = S_WAIT_ACK;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_WAIT_ACK: begin
                if (ack[idx]) begin
                    cnt_nxt = '0;
                    if (idx == IDX_LAST) begin
                        state_nxt = S_DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_GAP;
                    end
                end else if (cnt == TO_LAST) begin
                    state_nxt   = S_FAULT;
                    rst_out_nxt = '0;
                    busy_nxt    = 1'b0;
                    err_nxt     = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    idx_nxt     = idx + IDX_W'(1);
                    rst_out_nxt = (seq_rst_n << 1) | NUM_OUT'(1);
                    cnt_nxt     = '0;
                    state_nxt   = S_WAIT_ACK;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_DONE, S_FAULT: begin
            end
`ifdef RST_SEQ_REVERSE_ASSERT_EN
            S_ASSERT: begin
                if (cnt == GAP_LAST) begin
                    rst_out_nxt = seq_rst_n >> 1;
                    cnt_nxt     = '0;
                    if ((seq_rst_n >> 1) == '0) begin
                        state_nxt = S_HOLD;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
`endif
            default: begin
                state_nxt   = S_HOLD;
                idx_nxt     = '0;
                cnt_nxt     = '0;
                rst_out_nxt = '0;
                busy_nxt    = 1'b1;
                done_nxt    = 1'b0;
                err_nxt     = 1'b0;
            end
        endcase

        // Software re-reset outranks timeout and ACK handling.
        if (sw_rst) begin
            err_nxt  = 1'b0;
            done_nxt = 1'b0;
            busy_nxt = 1'b1;
            idx_nxt  = '0;
            cnt_nxt  = '0;
`ifdef RST_SEQ_REVERSE_ASSERT_EN
            if (state == S_DONE) begin
                state_nxt   = S_ASSERT;
                rst_out_nxt = seq_rst_n >> 1;
            end else begin
                state_nxt   = S_HOLD;
                rst_out_nxt = '0;
            end
`else
            state_nxt   = S_HOLD;
            rst_out_nxt = '0;
`endif
        end
    end

endmodule

`default_nettype wire
